// File: rtl/aq_memcpy_rd_ctrl.sv
// Memcpy read DMA: splits a transfer into 4 KB-safe bursts, one outstanding at a time, and
// streams beats into the FIFO with zero latency; AR waits on FIFO almost-full, R stalls on full.
module aq_memcpy_rd_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] SRC_ADRS,
    input  logic [LEN_WIDTH-1:0]  LENGTH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  RD_ARVALID,
    input  logic                  RD_ARREADY,
    output logic [ADDR_WIDTH-1:0] RD_ARADDR,
    output logic [7:0]            RD_ARLEN,
    input  logic                  RD_RVALID,
    output logic                  RD_RREADY,
    input  logic [DATA_WIDTH-1:0] RD_RDATA,
    input  logic                  RD_RLAST,
    output logic                  FIFO_WR_ENA,
    output logic [DATA_WIDTH-1:0] FIFO_WR_DATA,
    output logic                  FIFO_WR_LAST,
    input  logic                  FIFO_WR_ALM_FULL,
    input  logic                  FIFO_WR_FULL
);
    localparam int BPB     = DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);

    typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [8:0]            beat_q, beat_d;

    logic [ADDR_WIDTH-1:0] src_aligned;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LEN_WIDTH-1:0]  calc_rem;
    logic [12:0]           to_bnd;
    logic [8:0]            calc_beats;
    logic [8:0]            ar_beats;
    logic                  push;
    logic                  last_beat;

    assign src_aligned = SRC_ADRS & ~ADDR_WIDTH'(BPB - 1);

    // The first burst is sized straight from the request so ARVALID can rise on the REQ entry cycle.
    assign calc_addr = (state_q == IDLE) ? src_aligned : addr_q;
    assign calc_rem  = (state_q == IDLE) ? LENGTH : rem_q;
    assign to_bnd    = (13'd4096 - {1'b0, calc_addr[11:0]}) >> LOG_BPB;

    always_comb begin
        calc_beats = 9'(MAX_BURST);
        if (to_bnd < 13'(calc_beats)) calc_beats = to_bnd[8:0];
        if (calc_rem < LEN_WIDTH'(calc_beats)) calc_beats = calc_rem[8:0];
    end

    assign ar_beats     = {1'b0, arlen_q} + 9'd1;
    assign last_beat    = (beat_q == 9'd1);
    assign RD_RREADY    = (state_q == DATA) & ~FIFO_WR_FULL;
    assign push         = RD_RVALID & RD_RREADY;
    assign FIFO_WR_ENA  = push;
    assign FIFO_WR_DATA = RD_RDATA;
    assign FIFO_WR_LAST = push & last_beat;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        case (state_q)
            IDLE: begin
                // done_q marks the completion cycle, where a new request is not taken.
                if (START && !done_q) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (LENGTH != '0) begin
                        addr_d  = src_aligned;
                        rem_d   = LENGTH;
                        state_d = REQ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            REQ: begin
                if (arvalid_q && RD_ARREADY) begin
                    arvalid_d = 1'b0;
                    beat_d    = ar_beats;
                    addr_d    = addr_q + (ADDR_WIDTH'(ar_beats) << LOG_BPB);
                    rem_d     = rem_q - LEN_WIDTH'(ar_beats);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (push) begin
                    beat_d = beat_q - 9'd1;
                    if (RD_RLAST != last_beat) err_d = 1'b1;
                    if (last_beat) state_d = (rem_q != '0) ? REQ : FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Once raised, ARVALID is held until accepted, even if almost-full reasserts.
        if (state_d == REQ && !arvalid_q && !FIFO_WR_ALM_FULL) begin
            arvalid_d = 1'b1;
            araddr_d  = calc_addr;
            arlen_d   = 8'(calc_beats - 9'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign RD_ARVALID = arvalid_q;
    assign RD_ARADDR  = araddr_q;
    assign RD_ARLEN   = arlen_q;
endmodule
